mont_seq_ctrl: RTL

Sequencer and result stage for the radix-2 Montgomery modular multiplier. It accepts one operand set per start pulse and runs N bit-serial iterations, one per cycle, over an internal partial-sum register. It then applies the final conditional subtraction and returns X·Y·2^-N mod M through a start/busy/done handshake. It replaces the free-running kernel chain, which has no operand capture, no completion handshake and no final reduction, with a single controlled engine.

---
 rtl/mont_seq_ctrl_if.sv | 30 +++
 rtl/mont_seq_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mont_seq_ctrl_if.sv
// Handshake and operand bus for the Montgomery sequencer.
// Signals: start/X/Y/M go from the requester to the engine;
//          busy/done/err/result come back from the engine.
// Purpose: groups the request/operand and completion/result signals of mont_seq_ctrl.
// Latency: none (wiring only).
// Backpressure: none; the requester watches busy/done before issuing start.
interface mont_seq_ctrl_if #(
  parameter int N = 6
);
  logic         start;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic [N-1:0] M;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] result;

  // Requester side
  modport master (
    output start, X, Y, M,
    input  busy, done, err, result
  );

  // Engine side
  modport slave (
    input  start, X, Y, M,
    output busy, done, err, result
  );
endinterface

// File: rtl/mont_seq_ctrl.sv
// Purpose: radix-2 Montgomery multiplier sequencer; returns X*Y*2^-N mod M.
// Latency: N+1 edges from accept to done (1 edge when M is even -> err).
// Backpressure: start is only sampled in IDLE; a start while busy is dropped.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   bus.start    operation request, sampled only in IDLE
//   bus.X/Y/M    operands, captured on the accept edge (M must be odd)
//   bus.busy     high from the accept edge until the result edge
//   bus.done     one-cycle completion pulse; result/err valid with it
//   bus.err      raised with done when the captured modulus was even
//   bus.result   reduced product, held until the next done
module mont_seq_ctrl #(
  parameter int N = 6
) (
  input  logic          clk,
  input  logic          rst,
  mont_seq_ctrl_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    REDUCE = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [N:0]    s_q, s_d;        // partial sum, kept below 2M for in-range operands
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [N-1:0]  m_q, m_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [N-1:0]  result_q, result_d;

  // One bit-serial step. Both sums are carried at N+2 bits so the carry
  // out of S + Y + M survives until after the halving shift.
  logic [N+1:0]  t_sum;
  logic [N+1:0]  u_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      m_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      m_q      <= m_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    m_d      = m_q;
    busy_d   = busy_q;
    done_d   = 1'b0;     // done/err are single-cycle pulses
    err_d    = 1'b0;
    result_d = result_q;
    t_sum    = '0;
    u_sum    = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.X;
          y_d     = bus.Y;
          m_d     = bus.M;
          s_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = bus.M[0] ? ITER : ERR;
        end
      end

      ITER: begin
        t_sum = {1'b0, s_q} + (x_q[cnt_q] ? {2'b00, y_q} : '0);
        // Adding M when t is odd makes the sum even, so the shift is exact.
        u_sum = t_sum + (t_sum[0] ? {2'b00, m_q} : '0);
        s_d   = (N+1)'(u_sum >> 1);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = REDUCE;
        end
      end

      REDUCE: begin
        if (s_q >= {1'b0, m_q}) begin
          result_d = N'(s_q - {1'b0, m_q});
        end else begin
          result_d = N'(s_q);
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      ERR: begin
        result_d = '0;
        done_d   = 1'b1;
        err_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule
